// File: rtl/pipe_pkg.sv
// Shared types and sizing helpers for the elastic pipeline register chain.
package pipe_pkg;

    localparam int MAX_STAGES = 4;

    // Per-slot control: valid of the word offered to the slot, and its load enable.
    typedef struct packed {
        logic valid;
        logic load;
    } slot_ctrl_t;

    function automatic int occ_width(input int stages);
        return $clog2(stages + 2);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+data pipeline register; data only changes when a valid word is loaded.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  slot_ctrl_t       ctrl_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (ctrl_i.load) begin
            valid_d = ctrl_i.valid;
            if (ctrl_i.valid) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready register chain with bubble collapse, flush and occupancy count.
// Define PIPE_STAGE_CHAIN_SKID_EN to add a skid entry that makes in_ready a registered signal.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        flush,
    output logic [$clog2(STAGES+2)-1:0] occupancy
);
    localparam int OCC_W = occ_width(STAGES);

    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("pipe_stage_chain: STAGES=%0d outside 1..%0d", STAGES, MAX_STAGES);
    end

    slot_ctrl_t [STAGES-1:0] ctrl;
    logic [STAGES-1:0]       valid;
    logic [STAGES-1:0]       load;
    logic [WIDTH-1:0]        slot_data [STAGES];
    logic                    go, ahead_valid, adv;
    logic                    in_hs, out_hs;
    logic                    head_valid;
    logic [WIDTH-1:0]        head_data;
    logic [OCC_W-1:0]        occ_q, occ_d;

    // Walk from the output back: a slot advances when the slot ahead is empty or advancing too.
    always_comb begin
        load        = '0;
        go          = out_ready;
        ahead_valid = 1'b1;
        adv         = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv         = valid[i] & (~ahead_valid | go);
            load[i]     = ~valid[i] | adv;
            go          = adv;
            ahead_valid = valid[i];
        end
    end

`ifdef PIPE_STAGE_CHAIN_SKID_EN
    slot_ctrl_t       skid_ctrl;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    // The skid entry captures a word only when slot 0 is blocked, and drains as soon as slot 0 loads.
    assign in_ready   = ~skid_valid & ~reset;
    assign in_hs      = in_valid & in_ready;
    assign skid_ctrl  = '{valid: in_hs & ~skid_valid & ~load[0], load: ~skid_valid | load[0]};
    assign head_valid = skid_valid | in_hs;
    assign head_data  = skid_valid ? skid_data : in_data;

    pipe_slot #(.WIDTH(WIDTH)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush),
        .ctrl_i  (skid_ctrl),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );
`else
    assign in_ready   = load[0] & ~reset;
    assign in_hs      = in_valid & in_ready;
    assign head_valid = in_hs;
    assign head_data  = in_data;
`endif

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot
        logic             src_valid;
        logic [WIDTH-1:0] src_data;

        if (gi == 0) begin : g_head
            assign src_valid = head_valid;
            assign src_data  = head_data;
        end else begin : g_link
            assign src_valid = valid[gi-1];
            assign src_data  = slot_data[gi-1];
        end

        assign ctrl[gi] = '{valid: src_valid, load: load[gi]};

        pipe_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .reset   (reset),
            .flush_i (flush),
            .ctrl_i  (ctrl[gi]),
            .data_i  (src_data),
            .valid_o (valid[gi]),
            .data_o  (slot_data[gi])
        );
    end

    assign out_valid = valid[STAGES-1];
    assign out_data  = slot_data[STAGES-1];
    assign out_hs    = out_valid & out_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_hs & ~out_hs) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (out_hs & ~in_hs) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: queue-based reference model plus directed scenarios.
module tb_pipe_stage_chain;
    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam int OCC_W  = $clog2(STAGES + 2);
`ifdef PIPE_STAGE_CHAIN_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int CAP = STAGES + (SKID ? 1 : 0);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occupancy;

    int tests = 0;
    int fails = 0;

    pipe_stage_chain #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: ordered queue of words in the chain plus the edge each was accepted on.
    logic [WIDTH-1:0] mq [$];
    int               macc [$];
    int               cyc = 0;
    logic             prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    always @(negedge clk) begin
        logic exp_rdy, ihs, ohs;
        if (reset) begin
            chk_bit("rst_out_valid", out_valid, 1'b0);
            chk_val("rst_out_data", 64'(out_data), 64'(0));
            chk_val("rst_occupancy", 64'(occupancy), 64'(0));
            chk_bit("rst_in_ready", in_ready, 1'b0);
            mq.delete();
            macc.delete();
            prev_hold = 1'b0;
        end else begin
            chk_val("occupancy", 64'(occupancy), 64'(mq.size()));
            // Non-skid: only a completely full chain facing a stalled output refuses input.
            exp_rdy = SKID ? (mq.size() < CAP) : !(mq.size() == STAGES && !out_ready);
            chk_bit("in_ready", in_ready, exp_rdy);
            if (prev_hold) begin
                chk_bit("hold_valid", out_valid, 1'b1);
                chk_val("hold_data", 64'(out_data), 64'(prev_data));
            end
            if (out_valid) begin
                if (mq.size() == 0) begin
                    chk_bit("out_valid_when_empty", out_valid, 1'b0);
                end else begin
                    chk_val("out_data", 64'(out_data), 64'(mq[0]));
                    chk_bit("min_latency", (cyc - macc[0]) >= STAGES, 1'b1);
                end
            end
            ihs       = in_valid & in_ready;
            ohs       = out_valid & out_ready;
            prev_hold = out_valid & !ohs & !flush;
            prev_data = out_data;
            if (ohs && mq.size() > 0) begin
                void'(mq.pop_front());
                void'(macc.pop_front());
            end
            if (ihs) begin
                mq.push_back(in_data);
                macc.push_back(cyc);
            end
            if (flush) begin
                mq.delete();
                macc.delete();
            end
        end
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state, then release between edges.
        #2;
        chk_bit("reset_out_valid", out_valid, 1'b0);
        chk_val("reset_out_data", 64'(out_data), 64'(0));
        chk_val("reset_occupancy", 64'(occupancy), 64'(0));
        chk_bit("reset_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 chk_bit("release_in_ready", in_ready, 1'b1);
        step();

        // Fill then drain with the output stalled.
        out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA0 + i;
            step();
        end
        in_valid = 1'b0;
        #1;
        chk_val("fill_occupancy", 64'(occupancy), 64'(STAGES));
        chk_bit("fill_out_valid", out_valid, 1'b1);
        chk_val("fill_out_data", 64'(out_data), 64'(32'hA0));
        chk_bit("fill_in_ready", in_ready, SKID);
        out_ready = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            #1;
            chk_bit("drain_valid", out_valid, 1'b1);
            chk_val("drain_data", 64'(out_data), 64'(32'hA0 + i));
            step();
        end
        chk_bit("drain_empty_valid", out_valid, 1'b0);
        chk_val("drain_empty_occ", 64'(occupancy), 64'(0));

        // Bubble collapse while stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_valid = 1'b0;
        step();
        step();
        in_valid = 1'b1;
        in_data  = 32'h22;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk_val("bubble_occ", 64'(occupancy), 64'(2));
        chk_bit("bubble_in_ready", in_ready, 1'b1);
        chk_val("bubble_head", 64'(out_data), 64'(32'h11));
        out_ready = 1'b1;
        step();
        chk_bit("bubble_adjacent_valid", out_valid, 1'b1);
        chk_val("bubble_adjacent_data", 64'(out_data), 64'(32'h22));
        step();
        chk_bit("bubble_done", out_valid, 1'b0);

        // Flush with three words held and a fourth offered in the flush cycle.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h31 + i;
            step();
        end
        in_data = 32'h55;
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_bit("flush_out_valid", out_valid, 1'b0);
        chk_val("flush_occ", 64'(occupancy), 64'(0));
        out_ready = 1'b1;
        repeat (6) step();
        chk_bit("flush_no_leak", out_valid, 1'b0);

        // Streaming: 100 incrementing words, no gaps, first word after STAGES cycles.
        out_ready = 1'b1;
        for (int t = 0; t < STAGES + 102; t++) begin
            in_valid = (t < 100);
            in_data  = 32'h1000 + t;
            #1;
            if (t >= STAGES && t < STAGES + 100) begin
                chk_bit("stream_valid", out_valid, 1'b1);
                chk_val("stream_data", 64'(out_data), 64'(32'h1000 + t - STAGES));
            end else begin
                chk_bit("stream_idle", out_valid, 1'b0);
            end
            step();
        end
        chk_val("stream_occ", 64'(occupancy), 64'(0));

`ifdef PIPE_STAGE_CHAIN_SKID_EN
        // Output stalls in the same cycle as a push into a full chain: word lands in the skid entry.
        out_ready = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hC0 + i;
            step();
        end
        in_data   = 32'hC0 + STAGES;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        #1;
        chk_val("skid_occ", 64'(occupancy), 64'(STAGES + 1));
        chk_bit("skid_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i <= STAGES; i++) begin
            #1;
            chk_val("skid_drain", 64'(out_data), 64'(32'hC0 + i));
            step();
        end
        chk_val("skid_empty", 64'(occupancy), 64'(0));
`endif

        // Randomised traffic with varying backpressure and occasional flushes.
        for (int blk = 0; blk < 6; blk++) begin
            for (int t = 0; t < 500; t++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = $urandom;
                out_ready = ($urandom_range(0, 5) < blk);
                flush     = ($urandom_range(0, 79) == 0);
                step();
            end
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;

        // Reset asserted between edges with two words in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hD0 + i;
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk_bit("pre_reset_valid", out_valid, 1'b1);
        chk_val("pre_reset_data", 64'(out_data), 64'(32'hD0));
        chk_val("pre_reset_occ", 64'(occupancy), 64'(2));
        #2 reset = 1'b1;
        #1;
        chk_bit("async_reset_valid", out_valid, 1'b0);
        chk_val("async_reset_data", 64'(out_data), 64'(0));
        chk_val("async_reset_occ", 64'(occupancy), 64'(0));
        @(posedge clk);
        #3 reset = 1'b0;
        step();
        chk_bit("after_reset_in_ready", in_ready, 1'b1);
        chk_val("after_reset_occ", 64'(occupancy), 64'(0));
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
